alu_share_sched: RTL and testbench
==================================

// Module: alu_share_sched
// PURPOSE
//  Sequencer/arbiter sharing one 8-bit ALU between two requesters (0 = core decode, 1 = APB/I2C side).
//  Round-robin grant, valid/ready handshake on request and response, operands and result registered.
//  Sits between the requesters and the single alu instance; the only driver of the alu inputs.
// PARAMETERS
//  DW     8   operand/result width; must match the ALU (8)
//  FNW    3   ALU function code width (000 ADD .. 111 BEQ)
//  CNT_W  16  width of per-requester op counters (used only with ALU_SCHED_STATS_EN)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  req_valid    in   2      per requester: request valid; held until req_ready
//  req_ready    out  2      per requester: request accepted this cycle
//  req_fn       in   2*FNW  per requester: ALU function code ([FNW-1:0] = requester 0)
//  req_a        in   2*DW   per requester: operand ra
//  req_b        in   2*DW   per requester: operand rb / immediate
//  rsp_valid    out  2      per requester: result valid; held until rsp_ready
//  rsp_ready    in   2      per requester: result consumed
//  rsp_data     out  DW     result, shared bus, meaningful for the requester whose rsp_valid is high
//  rsp_br       out  1      branch-equal flag, meaningful with rsp_valid
//  alu_fn       out  FNW    to ALU alufn
//  alu_ra       out  DW     to ALU ra
//  alu_rb       out  DW     to ALU rb_or_imm
//  alu_out      in   DW     from ALU aluout
//  alu_br       in   1      from ALU br
//  cnt0, cnt1   out  CNT_W  completed ops per requester (ALU_SCHED_STATS_EN only)
// BEHAVIOUR
//  - FSM: IDLE -> EXEC -> RESP -> IDLE. Reset state IDLE.
//  - IDLE: if any req_valid, grant one; req_ready[g]=1 combinationally that cycle only;
//    latch fn/a/b of g into operand regs, record g; next state EXEC. No valid -> stay IDLE.
//  - Arbitration: both valid -> grant the requester not granted last; single valid -> grant it.
//    After reset, last-grant = 1 (requester 0 wins first tie).
//  - EXEC: alu_fn/ra/rb driven from operand regs (ALU is combinational); capture at end of cycle:
//    fn==BEQ: rsp_data<=0, rsp_br<=alu_br; else rsp_data<=alu_out, rsp_br<=0. Next RESP.
//    (ALU leaves br/aluout unassigned on the other opcode; controller never forwards them.)
//  - RESP: rsp_valid[g]=1, data/br stable; on rsp_ready[g] -> IDLE and last-grant<=g.
//    rsp_ready high before RESP is ignored; no timeout.
//  - Latency: accept at cycle N, rsp_valid at N+2; min 3 cycles per op; req_ready=0 outside IDLE.
//  - Arithmetic: DW-bit wrap-around, no carry/overflow reported (SUB 0x00-0x01 = 0xFF).
//  - Reset (any time, incl. mid-op): state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_br=0,
//    operand regs 0 (alu_fn=000, alu_ra=alu_rb=0), last-grant=1, counters 0; in-flight op dropped.
//  - req_valid dropped before ready is a protocol violation; behaviour then undefined.
// CONFIGURATION
//  ALU_SCHED_STATS_EN defined: cnt0/cnt1 increment by 1 on each rsp handshake of that requester,
//    saturate at all-ones, clear only on reset.
//  Not defined: cnt0/cnt1 ports absent; no counter logic.
// TESTING
//  1 Req0 ADD a=0x7F b=0x01 alone -> ready0 same cycle, rsp_valid0 two cycles later, data 0x80, br 0.
//  2 Both valid same cycle (SUB 0x00,0x01 / OR 0x0F,0xF0) -> req0 first data 0xFF, then req1 data 0xFF;
//    both held valid again -> req1 granted before req0 (alternation).
//  3 BEQ 0x55,0x55 then BEQ 0x55,0x54 -> data 0x00 br 1, then data 0x00 br 0; following AND 0xF0,0x3C -> 0x30 br 0.
//  4 rsp_ready0 held low 5 cycles -> rsp_valid0/data stable, req_ready both 0, req1 waits; released -> req1 granted next IDLE.
//  5 rst_n low during EXEC -> all outputs to reset values asynchronously; after release req0 wins first tie.
//  6 STATS_EN: 3 ops req0, 2 ops req1 -> cnt0=3, cnt1=2; CNT_W=2 with 5 ops req0 -> cnt0 stays 3.

Source files
------------

// File: rtl/alu_share_sched.sv
// rtl/alu_share_sched.sv - round-robin sequencer sharing one combinational ALU between two requesters
// Optional per-requester op counters: define ALU_SCHED_STATS_EN.
module alu_share_sched #(
    parameter int DW    = 8,
    parameter int FNW   = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*FNW-1:0] req_fn,
    input  logic [2*DW-1:0]  req_a,
    input  logic [2*DW-1:0]  req_b,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [DW-1:0]    rsp_data,
    output logic             rsp_br,
    output logic [FNW-1:0]   alu_fn,
    output logic [DW-1:0]    alu_ra,
    output logic [DW-1:0]    alu_rb,
    input  logic [DW-1:0]    alu_out,
    input  logic             alu_br
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [FNW-1:0] FN_BEQ = '1;

    state_t         state_q, state_d;
    logic           grant_q, grant_d;
    logic           last_q, last_d;
    logic [FNW-1:0] fn_q, fn_d;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic [DW-1:0]  data_q, data_d;
    logic           br_q, br_d;
    logic [1:0]     rsp_valid_q, rsp_valid_d;
    logic           pick;
    logic           rsp_done;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        fn_d        = fn_q;
        a_d         = a_q;
        b_d         = b_q;
        data_d      = data_q;
        br_d        = br_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = 2'b00;
        rsp_done    = 1'b0;
        // On a tie the requester not served last wins; otherwise the lone requester.
        pick        = (&req_valid) ? ~last_q : req_valid[1];
        case (state_q)
            IDLE: begin
                if (rst_n && (|req_valid)) begin
                    req_ready = pick ? 2'b10 : 2'b01;
                    grant_d   = pick;
                    fn_d      = pick ? req_fn[2*FNW-1:FNW] : req_fn[FNW-1:0];
                    a_d       = pick ? req_a[2*DW-1:DW]    : req_a[DW-1:0];
                    b_d       = pick ? req_b[2*DW-1:DW]    : req_b[DW-1:0];
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                // The ALU leaves the unused result undefined, so only the relevant one is forwarded.
                if (fn_q == FN_BEQ) begin
                    data_d = '0;
                    br_d   = alu_br;
                end else begin
                    data_d = alu_out;
                    br_d   = 1'b0;
                end
                rsp_valid_d = grant_q ? 2'b10 : 2'b01;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready[grant_q]) begin
                    rsp_done    = 1'b1;
                    rsp_valid_d = 2'b00;
                    last_d      = grant_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            fn_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            data_q      <= '0;
            br_q        <= 1'b0;
            rsp_valid_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            fn_q        <= fn_d;
            a_q         <= a_d;
            b_q         <= b_d;
            data_q      <= data_d;
            br_q        <= br_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign alu_fn    = fn_q;
    assign alu_ra    = a_q;
    assign alu_rb    = b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = data_q;
    assign rsp_br    = br_q;

`ifdef ALU_SCHED_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (rsp_done && !grant_q && !(&cnt0_q)) cnt0_d = cnt0_q + 1'b1;
        if (rsp_done &&  grant_q && !(&cnt1_q)) cnt1_d = cnt1_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_sched.sv
// tb/tb_alu_share_sched.sv - directed table-driven bench for alu_share_sched with a behavioural ALU
module tb_alu_share_sched;

    localparam int DW  = 8;
    localparam int FNW = 3;

    localparam logic [2:0] F_ADD = 3'b000;
    localparam logic [2:0] F_SUB = 3'b001;
    localparam logic [2:0] F_AND = 3'b010;
    localparam logic [2:0] F_OR  = 3'b011;
    localparam logic [2:0] F_BEQ = 3'b111;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [2*FNW-1:0] req_fn = '0;
    logic [2*DW-1:0]  req_a = '0;
    logic [2*DW-1:0]  req_b = '0;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready = '0;
    logic [DW-1:0]    rsp_data;
    logic             rsp_br;
    logic [FNW-1:0]   alu_fn;
    logic [DW-1:0]    alu_ra;
    logic [DW-1:0]    alu_rb;
    logic [DW-1:0]    alu_out;
    logic             alu_br;
`ifdef ALU_SCHED_STATS_EN
    logic [15:0]      cnt0, cnt1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Behavioural ALU; drives junk on the result the real ALU leaves undefined.
    always_comb begin
        alu_br = 1'b1;
        case (alu_fn)
            F_ADD:   alu_out = alu_ra + alu_rb;
            F_SUB:   alu_out = alu_ra - alu_rb;
            F_AND:   alu_out = alu_ra & alu_rb;
            F_OR:    alu_out = alu_ra | alu_rb;
            F_BEQ: begin
                alu_out = 8'hA5;
                alu_br  = (alu_ra == alu_rb);
            end
            default: alu_out = alu_ra ^ alu_rb;
        endcase
    end

    alu_share_sched #(.DW(DW), .FNW(FNW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fn(req_fn), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_br(rsp_br),
        .alu_fn(alu_fn), .alu_ra(alu_ra), .alu_rb(alu_rb),
        .alu_out(alu_out), .alu_br(alu_br)
`ifdef ALU_SCHED_STATS_EN
        , .cnt0(cnt0), .cnt1(cnt1)
`endif
    );

    typedef struct {
        int         id;
        logic [2:0] fn;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_d;
        logic       exp_br;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_req(input int id, input logic [2:0] fn, input logic [7:0] a, input logic [7:0] b);
        req_valid[id] = 1'b1;
        req_fn[id*FNW +: FNW] = fn;
        req_a[id*DW +: DW]    = a;
        req_b[id*DW +: DW]    = b;
    endtask

    // Entered in IDLE with the request already driven; leaves the op in EXEC.
    task automatic accept(input int id);
        logic [1:0] oh;
        oh = (id == 1) ? 2'b10 : 2'b01;
        #1 chk("req_ready grant", {30'd0, req_ready}, {30'd0, oh});
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
        #1 chk("req_ready exec", {30'd0, req_ready}, 32'd0);
        chk("rsp_valid exec", {30'd0, rsp_valid}, 32'd0);
    endtask

    task automatic finish(input int id, input logic [7:0] d, input logic br);
        logic [1:0] oh;
        oh = (id == 1) ? 2'b10 : 2'b01;
        @(posedge clk);
        #1 chk("rsp_valid resp", {30'd0, rsp_valid}, {30'd0, oh});
        chk("rsp_data", {24'd0, rsp_data}, {24'd0, d});
        chk("rsp_br", {31'd0, rsp_br}, {31'd0, br});
        rsp_ready[id] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[id] = 1'b0;
        #1 chk("rsp_valid after ack", {30'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, F_ADD, 8'h7F, 8'h01, 8'h80, 1'b0};
        vecs[1] = '{0, F_BEQ, 8'h55, 8'h55, 8'h00, 1'b1};
        vecs[2] = '{1, F_BEQ, 8'h55, 8'h54, 8'h00, 1'b0};
        vecs[3] = '{1, F_AND, 8'hF0, 8'h3C, 8'h30, 1'b0};
        vecs[4] = '{0, F_SUB, 8'h00, 8'h01, 8'hFF, 1'b0};
        vecs[5] = '{1, F_ADD, 8'hFF, 8'h01, 8'h00, 1'b0};
        vecs[6] = '{0, F_OR,  8'h0F, 8'hF0, 8'hFF, 1'b0};

        do_reset();
        #1 chk("reset rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("reset rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("reset alu_fn", {29'd0, alu_fn}, 32'd0);
        chk("reset req_ready idle", {30'd0, req_ready}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            set_req(vecs[i].id, vecs[i].fn, vecs[i].a, vecs[i].b);
            accept(vecs[i].id);
            finish(vecs[i].id, vecs[i].exp_d, vecs[i].exp_br);
        end

        // Tie after reset goes to requester 0, then alternation.
        do_reset();
        set_req(0, F_SUB, 8'h00, 8'h01);
        set_req(1, F_OR, 8'h0F, 8'hF0);
        accept(0);
        finish(0, 8'hFF, 1'b0);
        set_req(0, F_ADD, 8'h20, 8'h22);
        accept(1);
        finish(1, 8'hFF, 1'b0);
        accept(0);
        finish(0, 8'h42, 1'b0);

        // Back-pressure on the response holds everything off.
        set_req(0, F_ADD, 8'h01, 8'h02);
        accept(0);
        set_req(1, F_OR, 8'h0F, 8'hF0);
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            #1 chk("hold rsp_valid", {30'd0, rsp_valid}, 32'd1);
            chk("hold rsp_data", {24'd0, rsp_data}, 32'h03);
            chk("hold req_ready", {30'd0, req_ready}, 32'd0);
            @(posedge clk);
        end
        #1 rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[0] = 1'b0;
        accept(1);
        finish(1, 8'hFF, 1'b0);

        // Asynchronous reset while an op is in EXEC.
        set_req(1, F_ADD, 8'h11, 8'h22);
        accept(1);
        #2 rst_n = 1'b0;
        req_valid = 2'b11;
        #1 chk("midop rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("midop alu_fn", {29'd0, alu_fn}, 32'd0);
        chk("midop alu_ra", {24'd0, alu_ra}, 32'd0);
        chk("midop alu_rb", {24'd0, alu_rb}, 32'd0);
        chk("midop req_ready", {30'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_req(0, F_ADD, 8'h10, 8'h20);
        set_req(1, F_ADD, 8'h01, 8'h01);
        accept(0);
        finish(0, 8'h30, 1'b0);
        accept(1);
        finish(1, 8'h02, 1'b0);

`ifdef ALU_SCHED_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_req((i < 3) ? 0 : 1, F_ADD, 8'h01, 8'h01);
            accept((i < 3) ? 0 : 1);
            finish((i < 3) ? 0 : 1, 8'h02, 1'b0);
        end
        chk("cnt0", {16'd0, cnt0}, 32'd3);
        chk("cnt1", {16'd0, cnt1}, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
